// File: rtl/demux_1t4_ld_pkg.sv
// Shared constants for the 1-to-4 round-robin word distributor and its
// helper decoder: state encoding and slot geometry.
package demux_1t4_ld_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int NSLOT  = 4;
  localparam int SLOT_W = 2;

endpackage

// File: rtl/demux_1t4_ld_dec_2t4_en.sv
// Slot write-enable decoder: turns a 2-bit slot index plus an accept strobe
// into a one-hot per-slot enable, all zero when the strobe is low.
module dec_2t4_en
  import demux_1t4_ld_pkg::*;
(
  input  logic [SLOT_W-1:0] sel,
  input  logic              en,
  output logic [NSLOT-1:0]  onehot
);

  // One-hot decode of sel, gated by en
  always_comb begin
    onehot = 4'b0000;
    if (en) begin
      case (sel)
        2'd0:    onehot = 4'b0001;
        2'd1:    onehot = 4'b0010;
        2'd2:    onehot = 4'b0100;
        2'd3:    onehot = 4'b1000;
        default: onehot = 4'b0000;
      endcase
    end else begin
      onehot = 4'b0000;
    end
  end

endmodule

// File: rtl/demux_1t4_ld.sv
// Sequential 1-to-4 distributor: loads accepted words round-robin into four
// held registers, then holds the full set until the consumer acknowledges it.
module demux_1t4_ld
  import demux_1t4_ld_pkg::*;
#(
  parameter int n = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [n-1:0]        D_IN,
  input  logic                LD,
  output logic                RDY,
  input  logic                ACK,
  output logic [n-1:0]        D0,
  output logic [n-1:0]        D1,
  output logic [n-1:0]        D2,
  output logic [n-1:0]        D3,
  output logic [NSLOT-1:0]    VLD,
  output logic [SLOT_W-1:0]   SEL,
  output logic                FULL
);

  state_e             state_r;
  state_e             state_s;
  logic [SLOT_W-1:0]  sel_r;
  logic [NSLOT-1:0]   vld_r;
  logic [n-1:0]       d_r [NSLOT];
  logic               accept_s;
  logic               release_s;
  logic [NSLOT-1:0]   we_s;

  dec_2t4_en u_dec (
    .sel    (sel_r),
    .en     (accept_s),
    .onehot (we_s)
  );

  // Next-state and handshake decode from the current state
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    release_s = 1'b0;
    case (state_r)
      LOAD: begin
        accept_s = LD;
        if (LD && (sel_r == 2'd3)) begin
          state_s = HOLD;
        end else begin
          state_s = LOAD;
        end
      end
      HOLD: begin
        // LD is dropped here even when it arrives together with ACK
        release_s = ACK;
        if (ACK) begin
          state_s = LOAD;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = LOAD;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= LOAD;
    end else begin
      state_r <= state_s;
    end
  end

  // Slot registers, valid bits and round-robin pointer
  always_ff @(posedge CLK) begin
    if (RST) begin
      sel_r <= 2'd0;
      vld_r <= 4'b0000;
      for (int k = 0; k < NSLOT; k++) begin
        d_r[k] <= '0;
      end
    end else if (accept_s) begin
      // 2-bit wrap takes the pointer from 3 back to 0 on the set's last word
      sel_r <= sel_r + 2'd1;
      vld_r <= vld_r | we_s;
      for (int k = 0; k < NSLOT; k++) begin
        if (we_s[k]) begin
          d_r[k] <= D_IN;
        end
      end
    end else if (release_s) begin
      vld_r <= 4'b0000;
    end
  end

  assign RDY  = (state_r == LOAD);
  assign FULL = (state_r == HOLD);
  assign SEL  = sel_r;
  assign VLD  = vld_r;
  assign D0   = d_r[0];
  assign D1   = d_r[1];
  assign D2   = d_r[2];
  assign D3   = d_r[3];

endmodule

// File: tb/tb_demux_1t4_ld.sv
// Self-checking bench for demux_1t4_ld: directed test-plan scenarios plus
// randomized traffic, all compared against a word-count based reference model.
module tb_demux_1t4_ld;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] D_IN = 8'h00;
  logic       LD = 1'b0;
  logic       ACK = 1'b0;
  logic       RDY, FULL;
  logic [7:0] D0, D1, D2, D3;
  logic [3:0] VLD;
  logic [1:0] SEL;

  demux_1t4_ld #(.n(8)) dut (
    .CLK(CLK), .RST(RST), .D_IN(D_IN), .LD(LD), .RDY(RDY), .ACK(ACK),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3), .VLD(VLD), .SEL(SEL), .FULL(FULL)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;

  // reference model: slot contents plus number of words in the current set
  logic [7:0] m_d [4];
  int         m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit ld, input bit ack, input logic [7:0] din);
    if (rst) begin
      for (int k = 0; k < 4; k++) m_d[k] = 8'h00;
      m_cnt = 0;
    end else if (m_cnt < 4) begin
      if (ld) begin
        m_d[m_cnt] = din;
        m_cnt++;
      end
    end else if (ack) begin
      m_cnt = 0;
    end
  endtask

  task automatic check_all();
    check("d0", {24'h0, D0}, {24'h0, m_d[0]});
    check("d1", {24'h0, D1}, {24'h0, m_d[1]});
    check("d2", {24'h0, D2}, {24'h0, m_d[2]});
    check("d3", {24'h0, D3}, {24'h0, m_d[3]});
    check("vld", {28'h0, VLD}, 32'((1 << m_cnt) - 1));
    check("sel", {30'h0, SEL}, 32'(m_cnt % 4));
    check("rdy", {31'h0, RDY}, {31'h0, (m_cnt < 4)});
    check("full", {31'h0, FULL}, {31'h0, (m_cnt == 4)});
  endtask

  // apply one cycle of inputs, advance one edge, then compare against model
  task automatic step(input bit rst, input bit ld, input bit ack, input logic [7:0] din);
    RST = rst; LD = ld; ACK = ack; D_IN = din;
    #1;
    if (!rst && ld && RDY) n_acc++;
    @(posedge CLK);
    model_edge(rst, ld, ack, din);
    #1;
    check_all();
  endtask

  logic [7:0] fill_vals [4];

  initial begin
    fill_vals[0] = 8'h3C; fill_vals[1] = 8'hA5;
    fill_vals[2] = 8'h01; fill_vals[3] = 8'hFF;
    for (int k = 0; k < 4; k++) m_d[k] = 8'h00;

    // reset then idle
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("rst_vld", {28'h0, VLD}, 32'h0);
    check("rst_rdy", {31'h0, RDY}, 32'h1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00);

    // fill one set on consecutive cycles
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, fill_vals[i]);
    check("fill_d0", {24'h0, D0}, 32'h3C);
    check("fill_d3", {24'h0, D3}, 32'hFF);
    check("fill_full", {31'h0, FULL}, 32'h1);

    // hold protection
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'h77);
    check("hold_d1", {24'h0, D1}, 32'hA5);
    check("hold_vld", {28'h0, VLD}, 32'hF);

    // LD and ACK together in HOLD: word dropped, set released
    step(1'b0, 1'b1, 1'b1, 8'h55);
    check("ldack_d0", {24'h0, D0}, 32'h3C);
    check("ldack_vld", {28'h0, VLD}, 32'h0);
    check("ldack_rdy", {31'h0, RDY}, 32'h1);

    // gapped load, reset mid-set, reload
    step(1'b0, 1'b1, 1'b0, 8'h10);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h20);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("gap_vld", {28'h0, VLD}, 32'h3);
    check("gap_sel", {30'h0, SEL}, 32'h2);
    step(1'b1, 1'b1, 1'b1, 8'hEE);
    check("gap_rst_d0", {24'h0, D0}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 8'h99);
    check("gap_reload_d0", {24'h0, D0}, 32'h99);

    // sustained rate with LD and ACK tied high
    step(1'b1, 1'b0, 1'b0, 8'h00);
    n_acc = 0;
    for (int t = 0; t < 20; t++) begin
      step(1'b0, 1'b1, 1'b1, 8'(t));
      if (t == 8) begin
        check("sus_d0", {24'h0, D0}, 32'd5);
        check("sus_d1", {24'h0, D1}, 32'd6);
        check("sus_d2", {24'h0, D2}, 32'd7);
        check("sus_d3", {24'h0, D3}, 32'd8);
      end
    end
    check("sus_accepts", 32'(n_acc), 32'd16);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 70),
           ($urandom_range(0, 99) < 40), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
